// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared constants, rx FSM state type and frame-length helper
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  // Total line bits in one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_sync : 2-FF synchroniser for rx with falling-edge detect
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Preset to idle-high so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_param : parametrised UART receiver with valid/ready output
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int C_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int C_BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [C_CNT_W-1:0] C_HALF_M1   = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [C_CNT_W-1:0] C_FULL_M1   = C_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [C_BIT_W-1:0] C_LAST_DATA = C_BIT_W'(DATA_BITS - 1);
  localparam logic               C_LAST_STOP = 1'(STOP_BITS - 1);

  logic w_rx_s;
  logic w_fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_fall (w_fall)
  );

  rx_state_t              r_state, w_state_nxt;
  logic [C_CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [C_BIT_W-1:0]     r_bit_idx, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_par_acc, w_par_nxt;
  logic                   r_stop_idx, w_stop_nxt;
  logic                   w_done;
  logic                   w_ferr;
  logic                   w_mid;
  logic                   w_perr_word;

  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_ovr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_stop_idx <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par_acc  <= w_par_nxt;
      r_stop_idx <= w_stop_nxt;
    end
  end

  assign w_mid = (r_cnt == C_FULL_M1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par_acc;
    w_stop_nxt  = r_stop_idx;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == C_HALF_M1) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_par_nxt   = 1'b0;
          w_stop_nxt  = 1'b0;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_mid) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          w_par_nxt   = r_par_acc ^ w_rx_s;
          w_bit_nxt   = r_bit_idx + 1'b1;
          if (r_bit_idx == C_LAST_DATA)
            w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_mid) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = r_par_acc ^ w_rx_s;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_mid) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_ferr      = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
          end else if (r_stop_idx == C_LAST_STOP) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // r_par_acc holds XOR of data and parity bits once the frame is complete.
  assign w_perr_word = (PARITY == PAR_EVEN) ? r_par_acc :
                       (PARITY == PAR_ODD)  ? ~r_par_acc : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= 1'b0;
      if (w_done) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_perr  <= w_perr_word;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_param : directed bench for four receiver configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int NDUT = 4;
  localparam int DB [NDUT] = '{8, 8, 8, 5};
  localparam int PM [NDUT] = '{0, 1, 0, 0};
  localparam int SB [NDUT] = '{1, 1, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_v  [NDUT];
  logic rdy_v [NDUT];
  logic v  [NDUT];
  logic pe [NDUT];
  logic fe [NDUT];
  logic ov [NDUT];
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic [8:0] dat [NDUT];

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {1'b0, d2};
  assign dat[3] = {4'b0, d3};

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .data(d0), .valid(v[0]), .ready(rdy_v[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .data(d1), .valid(v[1]), .ready(rdy_v[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_d2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .data(d2), .valid(v[2]), .ready(rdy_v[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_d3 (
    .clk(clk), .rst(rst), .rx(rx_v[3]), .data(d3), .valid(v[3]), .ready(rdy_v[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fcnt2 = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int         idx;
    int         cyc;
    bit         ferr;
    logic [8:0] d;
    bit         pe;
  } ev_t;

  ev_t        evq [$];
  bit         m_valid [NDUT];
  logic [8:0] m_data  [NDUT];
  bit         m_pe    [NDUT];
  bit         rdy_q   [NDUT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic model_clear();
    evq.delete();
    for (int i = 0; i < NDUT; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_pe[i]    = 1'b0;
    end
  endtask

  // Model: outcome of a frame is decided from its bit values alone and
  // lands at rx fall + 2 + CPB/2 + CPB*(bits_after_start-1) + CPB + 1.
  task automatic send(input int i, input logic [8:0] d, input bit par_bit,
                      input bit [1:0] stops, input int abort_bit, input bit hold_low);
    int         n;
    int         bad_k;
    int         c0;
    logic [15:0] fb;
    logic [8:0] dm;
    bit         ones;
    bit         perr;
    n = 0; bad_k = 0; fb = '0; c0 = cyc;
    dm = d & ((9'h1 << DB[i]) - 9'h1);
    for (int b = 0; b < DB[i]; b++) begin fb[n] = d[b]; n++; end
    if (PM[i] != 0) begin fb[n] = par_bit; n++; end
    for (int s = 0; s < SB[i]; s++) begin
      fb[n] = stops[s]; n++;
      if (!stops[s] && bad_k == 0) bad_k = n;
    end
    ones = ^dm;
    perr = (PM[i] == 1) ? (ones ^ par_bit) : (PM[i] == 2) ? ~(ones ^ par_bit) : 1'b0;
    if (abort_bit < 0) begin
      if (bad_k != 0)
        evq.push_back('{i, c0 + 2 + CPB/2 + CPB*(bad_k-1) + CPB + 1, 1'b1, 9'h0, 1'b0});
      else
        evq.push_back('{i, c0 + 2 + CPB/2 + CPB*(n-1) + CPB + 1, 1'b0, dm, perr});
    end
    rx_v[i] = 1'b0;
    tick(CPB);
    for (int b = 0; b < n; b++) begin
      rx_v[i] = fb[b];
      if (b == abort_bit) begin
        tick(CPB/2);
        return;
      end
      tick(CPB);
    end
    if (!hold_low) rx_v[i] = 1'b1;
  endtask

  // Per-cycle comparison of every DUT against the model.
  initial begin : p_compare
    bit  cmp, fer, ovr;
    ev_t e;
    ev_t keep [$];
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NDUT; i++) rdy_q[i] = rdy_v[i];
      @(negedge clk);
      if (chk_en && !rst) begin
        for (int i = 0; i < NDUT; i++) begin
          cmp = 1'b0; fer = 1'b0; ovr = 1'b0;
          e = '{0, 0, 1'b0, 9'h0, 1'b0};
          for (int k = 0; k < evq.size(); k++)
            if (evq[k].idx == i && evq[k].cyc == cyc) begin
              e = evq[k];
              if (e.ferr) fer = 1'b1; else cmp = 1'b1;
            end
          if (cmp) begin
            if (!m_valid[i] || rdy_q[i]) begin
              m_valid[i] = 1'b1; m_data[i] = e.d; m_pe[i] = e.pe;
            end else ovr = 1'b1;
          end else if (m_valid[i] && rdy_q[i]) m_valid[i] = 1'b0;
          check($sformatf("valid[%0d]", i), 32'(v[i]), 32'(m_valid[i]));
          check($sformatf("frame_err[%0d]", i), 32'(fe[i]), 32'(fer));
          check($sformatf("overrun[%0d]", i), 32'(ov[i]), 32'(ovr));
          if (m_valid[i]) begin
            check($sformatf("data[%0d]", i), 32'(dat[i]), 32'(m_data[i]));
            check($sformatf("parity_err[%0d]", i), 32'(pe[i]), 32'(m_pe[i]));
          end
        end
        keep = {};
        foreach (evq[k]) if (evq[k].cyc > cyc) keep.push_back(evq[k]);
        evq = keep;
      end
    end
  end

  always @(negedge clk) if (!rst && fe[2]) fcnt2++;

  initial begin : p_watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int c0;
    for (int i = 0; i < NDUT; i++) begin rx_v[i] = 1'b1; rdy_v[i] = 1'b1; end
    model_clear();
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("reset valid[%0d]", i), 32'(v[i]), 32'd0);
      check($sformatf("reset data[%0d]", i), 32'(dat[i]), 32'd0);
      check($sformatf("reset parity_err[%0d]", i), 32'(pe[i]), 32'd0);
      check($sformatf("reset frame_err[%0d]", i), 32'(fe[i]), 32'd0);
      check($sformatf("reset overrun[%0d]", i), 32'(ov[i]), 32'd0);
    end
    tick(3);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(4);

    // 8N1 0xA5, ready=1: latency 2+8+16*8+16+1 = 155
    c0 = cyc;
    fork
      send(0, 9'hA5, 1'b0, 2'b11, -1, 1'b0);
      begin
        wait_cyc(c0 + 154);
        check("latency valid before", 32'(v[0]), 32'd0);
        wait_cyc(c0 + 155);
        check("latency valid at", 32'(v[0]), 32'd1);
        check("latency data", 32'(d0), 32'hA5);
      end
    join
    tick(CPB);

    // ready=0: 0x3C held, 0x5A overruns
    rdy_v[0] = 1'b0;
    send(0, 9'h3C, 1'b0, 2'b11, -1, 1'b0);
    send(0, 9'h5A, 1'b0, 2'b11, -1, 1'b0);
    tick(CPB);
    check("held data 3C", 32'(d0), 32'h3C);
    check("held valid", 32'(v[0]), 32'd1);
    rdy_v[0] = 1'b1;
    tick(2);
    check("valid after ready", 32'(v[0]), 32'd0);

    // 8E1
    rdy_v[1] = 1'b0;
    send(1, 9'h03, 1'b0, 2'b11, -1, 1'b0);
    tick(CPB);
    check("8E1 data 03", 32'(d1), 32'h03);
    check("8E1 perr 03", 32'(pe[1]), 32'd0);
    rdy_v[1] = 1'b1; tick(1); rdy_v[1] = 1'b0;
    send(1, 9'h07, 1'b0, 2'b11, -1, 1'b0);
    tick(CPB);
    check("8E1 data 07", 32'(d1), 32'h07);
    check("8E1 perr 07", 32'(pe[1]), 32'd1);
    rdy_v[1] = 1'b1;
    tick(CPB);

    // 8N2: bad second stop, then break held 40 bit times
    send(2, 9'h81, 1'b0, 2'b01, -1, 1'b1);
    tick(40 * CPB);
    check("break frame_err count", 32'(fcnt2), 32'd1);
    rx_v[2] = 1'b1;
    tick(3 * CPB);
    rdy_v[2] = 1'b0;
    send(2, 9'h42, 1'b0, 2'b11, -1, 1'b0);
    tick(2 * CPB);
    check("8N2 data 42", 32'(d2), 32'h42);
    check("8N2 valid", 32'(v[2]), 32'd1);
    rdy_v[2] = 1'b1;
    tick(CPB);

    // glitch shorter than half a bit
    rx_v[0] = 1'b0; tick(4); rx_v[0] = 1'b1;
    tick(2 * CPB);
    rdy_v[0] = 1'b0;
    send(0, 9'h11, 1'b0, 2'b11, -1, 1'b0);
    tick(CPB);
    check("post-glitch data 11", 32'(d0), 32'h11);
    check("post-glitch valid", 32'(v[0]), 32'd1);
    rdy_v[0] = 1'b1;
    tick(CPB);

    // reset during data bit 3 of 0xFF
    send(0, 9'hFF, 1'b0, 2'b11, 3, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst valid", 32'(v[0]), 32'd0);
    check("midrst data", 32'(d0), 32'd0);
    check("midrst parity_err", 32'(pe[0]), 32'd0);
    check("midrst frame_err", 32'(fe[0]), 32'd0);
    check("midrst overrun", 32'(ov[0]), 32'd0);
    model_clear();
    rx_v[0] = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    rdy_v[0] = 1'b0;
    send(0, 9'h96, 1'b0, 2'b11, -1, 1'b0);
    tick(CPB);
    check("post-reset data 96", 32'(d0), 32'h96);
    rdy_v[0] = 1'b1;

    // 5N1
    rdy_v[3] = 1'b0;
    send(3, 9'h15, 1'b0, 2'b11, -1, 1'b0);
    tick(CPB);
    check("5N1 data 15", 32'(d3), 32'h15);
    check("5N1 valid", 32'(v[3]), 32'd1);
    rdy_v[3] = 1'b1;
    tick(2 * CPB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver; successor to the fixed 8-bit, one-sample-per-clock receiver. It generates bit timing internally from the system clock and supports configurable data width, parity and stop bits. It synchronises and glitch-filters rx, and presents each received word on a valid/ready handshake with error flags. Sits between the board rx pin and downstream consumers (FIFO, command decoder, display logic).

Parameters:
CLKS_PER_BIT, 16, system clocks per bit period; legal range >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits checked; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
rx  input  1  serial line; idle high; asynchronous to clk.
data  output  DATA_BITS  received word, LSB first on the line.
valid  output  1  data holds an unconsumed word.
ready  input  1  consumer accepts data when valid & ready.
parity_err  output  1  sideband for data; meaningful only while valid=1.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: completed word dropped because valid was still held.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; counters cleared.
  - Outputs: data=0, valid=0, parity_err=0, frame_err=0, overrun=0.
  - Synchroniser flops preset to 1, so reset does not produce a false start.
- rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - Falling edge on rx_s (previous 1, current 0) -> START; clear clock counter.
- START:
  - At count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s=1: glitch; return to IDLE with no output activity.
  - rx_s=0: -> DATA; clear counter and bit index.
- DATA:
  - Sample every CLKS_PER_BIT clocks, at mid-bit.
  - Shift in LSB first; bit index 0..DATA_BITS-1.
  - After the last bit -> PARITY if PARITY!=0, else STOP.
- PARITY:
  - Sample one bit. Error if XOR(data bits, parity bit) is 1 for even, or 0 for odd.
- STOP:
  - Sample STOP_BITS bits at mid-bit.
  - Any stop sample 0: frame_err pulses for one cycle on the clock after that sample; word is discarded; -> WAIT_IDLE.
  - All stop samples 1: word completes on the clock after the final stop sample; -> IDLE. The next start edge is accepted immediately, so back-to-back frames are supported.
- WAIT_IDLE:
  - Remain until rx_s=1, then -> IDLE. A break condition therefore produces exactly one frame_err.
- Word completion:
  - valid=0, or valid & ready in the same cycle: load data and parity_err, set valid=1.
  - valid=1 & ready=0: pulse overrun for one cycle; keep old data and parity_err.
- Handshake:
  - valid & ready with no completion that cycle: valid->0.
  - data is stable while valid=1.
- Latency: rx pin falling edge to valid = 2 (sync) + CLKS_PER_BIT/2 + CLKS_PER_BIT*(DATA_BITS + parity bit + STOP_BITS - 1) + CLKS_PER_BIT + 1 clocks.
- Counter width: $clog2(CLKS_PER_BIT). Bit index width: $clog2(DATA_BITS+1).
- Parity and data are held in registers; no combinational path from rx to any output.
- Reset mid-frame: abort immediately. The first full frame after rst deasserts (and after rx returns idle) is received correctly.

Decomposition:
- Shared package uart_pkg:
  - Parity mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - rx FSM state enum.
  - Helper function computing frame length in bits.
- Sub-module uart_rx_sync:
  - 2-FF synchroniser, reset to 1.
  - Falling-edge detect output (fall) and synchronised level (rx_s).

Test Plan:
- 8N1, CLKS_PER_BIT=16, ready=1; send 0xA5 -> valid pulses 1 cycle with data=0xA5, parity_err=0; exact latency per formula.
- 8N1, ready=0; send 0x3C then 0x5A -> valid stays high with data=0x3C; overrun pulses once at the end of the second frame; then ready=1 -> valid drops.
- PARITY=1 (even), 8E1; send 0x03 with parity bit 0 -> data=0x03, parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1 with data=0x07.
- 8N2; send 0x81 with second stop bit 0 -> frame_err one-cycle pulse, no valid. Hold rx low for 40 bit times -> no further frame_err. Release rx, send 0x42 -> data=0x42.
- Glitch: rx low for 4 clocks (< CLKS_PER_BIT/2) -> no valid, no error, FSM back in IDLE; a following 0x11 frame is received correctly.
- Reset mid-frame: assert rst during data bit 3 of 0xFF -> all outputs 0 asynchronously. Deassert; send 0x96 -> data=0x96; DATA_BITS=5 variant, send 0x15 -> data=5'h15.
